// File: rtl/load_store_unit_if.sv
// Bundle of the execute-side request, data-memory bus and writeback response of the load/store unit.
// The master modport is the LSU's own view; slave is the view of the surrounding pipeline and memory.
interface load_store_unit_if #(
  parameter int N    = 32,
  parameter int RD_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic [N-1:0]    alu_result;
  logic [N-1:0]    store_data;
  logic [2:0]      mem_op;
  logic            is_store;
  logic [RD_W-1:0] rd_in;

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [N-1:0]    dmem_addr;
  logic            dmem_we;
  logic [N-1:0]    dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_rsp_valid;
  logic [N-1:0]    dmem_rdata;

  logic            resp_valid;
  logic [N-1:0]    resp_data;
  logic [RD_W-1:0] resp_rd;
  logic            resp_fault;

  modport master (
    input  req_valid, alu_result, store_data, mem_op, is_store, rd_in,
    output req_ready,
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    output resp_valid, resp_data, resp_rd, resp_fault
  );

  modport slave (
    output req_valid, alu_result, store_data, mem_op, is_store, rd_in,
    input  req_ready,
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    input  resp_valid, resp_data, resp_rd, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage after the ALU: one byte/half/word access in flight, misaligned or illegal
// accesses are answered with a fault without touching memory.
module load_store_unit #(
  parameter int N    = 32,
  parameter int RD_W = 5
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [1:0]      offset_q, offset_d;
  logic [2:0]      op_q, op_d;
  logic            store_q, store_d;
  logic [RD_W-1:0] rd_q, rd_d;

  logic            dmemReqValid_q, dmemReqValid_d;
  logic [N-1:0]    dmemAddr_q, dmemAddr_d;
  logic            dmemWe_q, dmemWe_d;
  logic [N-1:0]    dmemWdata_q, dmemWdata_d;
  logic [3:0]      dmemWstrb_q, dmemWstrb_d;
  logic            respValid_q, respValid_d;
  logic [N-1:0]    respData_q, respData_d;
  logic [RD_W-1:0] respRd_q, respRd_d;
  logic            respFault_q, respFault_d;

  logic [1:0]      reqOffset;
  logic            reqFault;
  logic [3:0]      storeStrb;
  logic [N-1:0]    storeWord;
  logic [N-1:0]    loadLane;
  logic [N-1:0]    loadData;

  assign reqOffset = bus.alu_result[1:0];

  // mem_op[1:0] is the access size (0 byte, 1 half, 2 word) for both loads and stores
  always_comb begin
    reqFault = 1'b0;
    if (bus.is_store) begin
      if (bus.mem_op > 3'd2) reqFault = 1'b1;
    end else begin
      if (bus.mem_op == 3'd3 || bus.mem_op == 3'd6 || bus.mem_op == 3'd7) reqFault = 1'b1;
    end
    if (bus.mem_op[1:0] == 2'd1 && reqOffset[0]) reqFault = 1'b1;
    if (bus.mem_op[1:0] == 2'd2 && reqOffset != 2'd0) reqFault = 1'b1;
  end

  always_comb begin
    storeStrb = 4'b1111;
    storeWord = bus.store_data;
    case (bus.mem_op[1:0])
      2'd0: begin
        storeStrb = 4'b0001 << reqOffset;
        storeWord = {4{bus.store_data[7:0]}};
      end
      2'd1: begin
        storeStrb = 4'b0011 << {reqOffset[1], 1'b0};
        storeWord = {2{bus.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign loadLane = bus.dmem_rdata >> {offset_q, 3'b000};

  always_comb begin
    case (op_q)
      3'd0:    loadData = {{24{loadLane[7]}}, loadLane[7:0]};
      3'd1:    loadData = {{16{loadLane[15]}}, loadLane[15:0]};
      3'd4:    loadData = {24'd0, loadLane[7:0]};
      3'd5:    loadData = {16'd0, loadLane[15:0]};
      default: loadData = loadLane;
    endcase
  end

  // Output registers are loaded together with the state so each one reflects the state it enters
  always_comb begin
    state_d        = state_q;
    offset_d       = offset_q;
    op_d           = op_q;
    store_d        = store_q;
    rd_d           = rd_q;
    dmemReqValid_d = 1'b0;
    dmemAddr_d     = dmemAddr_q;
    dmemWe_d       = dmemWe_q;
    dmemWdata_d    = dmemWdata_q;
    dmemWstrb_d    = dmemWstrb_q;
    respValid_d    = 1'b0;
    respData_d     = respData_q;
    respRd_d       = respRd_q;
    respFault_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          offset_d = reqOffset;
          op_d     = bus.mem_op;
          store_d  = bus.is_store;
          rd_d     = bus.rd_in;
          if (reqFault) begin
            state_d     = RESP;
            respValid_d = 1'b1;
            respFault_d = 1'b1;
            respData_d  = '0;
            respRd_d    = bus.rd_in;
          end else begin
            state_d        = REQ;
            dmemReqValid_d = 1'b1;
            dmemAddr_d     = {bus.alu_result[N-1:2], 2'b00};
            dmemWe_d       = bus.is_store;
            dmemWdata_d    = bus.is_store ? storeWord : '0;
            dmemWstrb_d    = bus.is_store ? storeStrb : 4'b0000;
          end
        end
      end
      REQ: begin
        dmemReqValid_d = 1'b1;
        if (bus.dmem_req_ready) begin
          dmemReqValid_d = 1'b0;
          state_d        = WAIT;
        end
      end
      WAIT: begin
        if (bus.dmem_rsp_valid) begin
          state_d     = RESP;
          respValid_d = 1'b1;
          respData_d  = store_q ? '0 : loadData;
          respRd_d    = rd_q;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      offset_q       <= '0;
      op_q           <= '0;
      store_q        <= 1'b0;
      rd_q           <= '0;
      dmemReqValid_q <= 1'b0;
      dmemAddr_q     <= '0;
      dmemWe_q       <= 1'b0;
      dmemWdata_q    <= '0;
      dmemWstrb_q    <= '0;
      respValid_q    <= 1'b0;
      respData_q     <= '0;
      respRd_q       <= '0;
      respFault_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      offset_q       <= offset_d;
      op_q           <= op_d;
      store_q        <= store_d;
      rd_q           <= rd_d;
      dmemReqValid_q <= dmemReqValid_d;
      dmemAddr_q     <= dmemAddr_d;
      dmemWe_q       <= dmemWe_d;
      dmemWdata_q    <= dmemWdata_d;
      dmemWstrb_q    <= dmemWstrb_d;
      respValid_q    <= respValid_d;
      respData_q     <= respData_d;
      respRd_q       <= respRd_d;
      respFault_q    <= respFault_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.dmem_req_valid = dmemReqValid_q;
  assign bus.dmem_addr      = dmemAddr_q;
  assign bus.dmem_we        = dmemWe_q;
  assign bus.dmem_wdata     = dmemWdata_q;
  assign bus.dmem_wstrb     = dmemWstrb_q;
  assign bus.resp_valid     = respValid_q;
  assign bus.resp_data      = respData_q;
  assign bus.resp_rd        = respRd_q;
  assign bus.resp_fault     = respFault_q;

endmodule
